// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction-fetch (I) and data (D) requesters; one transaction in flight.
// Grant to mem_req_valid is 1 cycle and the owner's response strobe follows mem_resp_valid by 1 cycle; mem_req_ready stalls the request.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        i_req_valid,
  input  logic [63:0] i_req_addr,
  output logic        i_req_ready,
  output logic        i_resp_valid,
  output logic [63:0] i_resp_data,
  output logic        i_resp_exc,
  input  logic        d_req_valid,
  input  logic        d_req_wren,
  input  logic [7:0]  d_req_mask,
  input  logic [63:0] d_req_addr,
  input  logic [63:0] d_req_data,
  output logic        d_req_ready,
  output logic        d_resp_valid,
  output logic [63:0] d_resp_data,
  output logic        d_resp_exc,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_wren,
  output logic [7:0]  mem_mask,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_data,
  input  logic        mem_resp_valid,
  input  logic [63:0] mem_resp_data,
  input  logic        mem_resp_exc,
  output logic        err_spurious
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;  // 1 = D owns the transaction
  logic        wren_q, wren_d;
  logic [7:0]  mask_q, mask_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] data_q, data_d;
  logic [3:0]  streak_q, streak_d;
  logic        i_vld_q, i_vld_d, d_vld_q, d_vld_d;
  logic [63:0] i_dat_q, i_dat_d, d_dat_q, d_dat_d;
  logic        i_exc_q, i_exc_d, d_exc_q, d_exc_d;
  logic        err_q, err_d;
  logic        grant_i, grant_d;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    wren_d   = wren_q;
    mask_d   = mask_q;
    addr_d   = addr_q;
    data_d   = data_q;
    streak_d = streak_q;
    i_vld_d  = 1'b0;
    d_vld_d  = 1'b0;
    i_dat_d  = i_dat_q;
    d_dat_d  = d_dat_q;
    i_exc_d  = i_exc_q;
    d_exc_d  = d_exc_q;
    err_d    = err_q | (mem_resp_valid && (state_q != RESP));
    grant_i  = 1'b0;
    grant_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // D has priority until I has watched LIMIT consecutive D grants go by
        if (d_req_valid && !(i_req_valid && (streak_q == LIMIT))) begin
          grant_d = 1'b1;
        end else if (i_req_valid) begin
          grant_i = 1'b1;
        end
        if (grant_d) begin
          owner_d  = 1'b1;
          wren_d   = d_req_wren;
          mask_d   = d_req_mask;
          addr_d   = d_req_addr;
          data_d   = d_req_data;
          state_d  = REQ;
          if (!i_req_valid)           streak_d = 4'd0;
          else if (streak_q >= LIMIT) streak_d = LIMIT;
          else                        streak_d = streak_q + 4'd1;
        end else if (grant_i) begin
          owner_d  = 1'b0;
          wren_d   = 1'b0;
          mask_d   = 8'hFF;
          addr_d   = i_req_addr;
          data_d   = 64'd0;
          streak_d = 4'd0;
          state_d  = REQ;
        end
      end
      REQ: begin
        if (mem_req_ready) state_d = RESP;
      end
      RESP: begin
        if (mem_resp_valid) begin
          if (owner_q) begin
            d_vld_d = 1'b1;
            d_dat_d = mem_resp_data;
            d_exc_d = mem_resp_exc;
          end else begin
            i_vld_d = 1'b1;
            i_dat_d = mem_resp_data;
            i_exc_d = mem_resp_exc;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      wren_q   <= 1'b0;
      mask_q   <= 8'd0;
      addr_q   <= 64'd0;
      data_q   <= 64'd0;
      streak_q <= 4'd0;
      i_vld_q  <= 1'b0;
      d_vld_q  <= 1'b0;
      i_dat_q  <= 64'd0;
      d_dat_q  <= 64'd0;
      i_exc_q  <= 1'b0;
      d_exc_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      wren_q   <= wren_d;
      mask_q   <= mask_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      streak_q <= streak_d;
      i_vld_q  <= i_vld_d;
      d_vld_q  <= d_vld_d;
      i_dat_q  <= i_dat_d;
      d_dat_q  <= d_dat_d;
      i_exc_q  <= i_exc_d;
      d_exc_q  <= d_exc_d;
      err_q    <= err_d;
    end
  end

  assign i_req_ready   = grant_i;
  assign d_req_ready   = grant_d;
  assign mem_req_valid = (state_q == REQ);
  assign mem_wren      = wren_q;
  assign mem_mask      = mask_q;
  assign mem_addr      = addr_q;
  assign mem_data      = data_q;
  assign i_resp_valid  = i_vld_q;
  assign i_resp_data   = i_dat_q;
  assign i_resp_exc    = i_exc_q;
  assign d_resp_valid  = d_vld_q;
  assign d_resp_data   = d_dat_q;
  assign d_resp_exc    = d_exc_q;
  assign err_spurious  = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs change 1 time unit after the rising edge, outputs sampled 1 unit later.
module tb_mem_port_arbiter;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        i_req_valid = 1'b0;
  logic [63:0] i_req_addr = '0;
  logic        i_req_ready, i_resp_valid, i_resp_exc;
  logic [63:0] i_resp_data;
  logic        d_req_valid = 1'b0, d_req_wren = 1'b0;
  logic [7:0]  d_req_mask = '0;
  logic [63:0] d_req_addr = '0, d_req_data = '0;
  logic        d_req_ready, d_resp_valid, d_resp_exc;
  logic [63:0] d_resp_data;
  logic        mem_req_valid, mem_wren;
  logic        mem_req_ready = 1'b0;
  logic [7:0]  mem_mask;
  logic [63:0] mem_addr, mem_data;
  logic        mem_resp_valid = 1'b0, mem_resp_exc = 1'b0;
  logic [63:0] mem_resp_data = '0;
  logic        err_spurious;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .CLK(CLK), .RESET(RESET),
    .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_ready(i_req_ready),
    .i_resp_valid(i_resp_valid), .i_resp_data(i_resp_data), .i_resp_exc(i_resp_exc),
    .d_req_valid(d_req_valid), .d_req_wren(d_req_wren), .d_req_mask(d_req_mask),
    .d_req_addr(d_req_addr), .d_req_data(d_req_data), .d_req_ready(d_req_ready),
    .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data), .d_resp_exc(d_resp_exc),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_wren(mem_wren),
    .mem_mask(mem_mask), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .mem_resp_exc(mem_resp_exc),
    .err_spurious(err_spurious)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".ready"}, {62'd0, i_req_ready, d_req_ready}, 64'd0);
    chk({tag, ".rvld"}, {62'd0, i_resp_valid, d_resp_valid}, 64'd0);
    chk({tag, ".idat"}, i_resp_data, 64'd0);
    chk({tag, ".ddat"}, d_resp_data, 64'd0);
    chk({tag, ".exc"}, {62'd0, i_resp_exc, d_resp_exc}, 64'd0);
    chk({tag, ".mvld"}, {62'd0, mem_req_valid, mem_wren}, 64'd0);
    chk({tag, ".mmask"}, {56'd0, mem_mask}, 64'd0);
    chk({tag, ".maddr"}, mem_addr, 64'd0);
    chk({tag, ".mdata"}, mem_data, 64'd0);
    chk({tag, ".err"}, {63'd0, err_spurious}, 64'd0);
  endtask

  // Full transaction from an IDLE cycle: grant, REQ held for 'stall' cycles, response, strobe.
  task automatic xact(input string tag, input bit is_d, input bit wren, input logic [7:0] mask,
                      input logic [63:0] addr, input logic [63:0] wdat, input int stall,
                      input logic [63:0] rdat, input bit rexc);
    if (is_d) begin
      d_req_valid = 1'b1; d_req_wren = wren; d_req_mask = mask;
      d_req_addr = addr; d_req_data = wdat;
    end else begin
      i_req_valid = 1'b1; i_req_addr = addr;
    end
    #1;
    chk({tag, ".ready"}, {62'd0, i_req_ready, d_req_ready}, is_d ? 64'd1 : 64'd2);
    chk({tag, ".mvld0"}, {63'd0, mem_req_valid}, 64'd0);
    tick();
    i_req_valid = 1'b0;
    d_req_valid = 1'b0;
    for (int k = 0; k <= stall; k++) begin
      mem_req_ready = (k == stall);
      #1;
      chk({tag, ".mvld"}, {63'd0, mem_req_valid}, 64'd1);
      chk({tag, ".maddr"}, mem_addr, addr);
      chk({tag, ".mwren"}, {63'd0, mem_wren}, is_d ? {63'd0, wren} : 64'd0);
      chk({tag, ".mmask"}, {56'd0, mem_mask}, is_d ? {56'd0, mask} : 64'hFF);
      chk({tag, ".mdata"}, mem_data, is_d ? wdat : 64'd0);
      tick();
    end
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_data = rdat; mem_resp_exc = rexc;
    #1;
    chk({tag, ".mvld_off"}, {63'd0, mem_req_valid}, 64'd0);
    chk({tag, ".early"}, {62'd0, i_resp_valid, d_resp_valid}, 64'd0);
    tick();
    mem_resp_valid = 1'b0; mem_resp_data = '0; mem_resp_exc = 1'b0;
    #1;
    chk({tag, ".strobe"}, {62'd0, i_resp_valid, d_resp_valid}, is_d ? 64'd1 : 64'd2);
    chk({tag, ".rdat"}, is_d ? d_resp_data : i_resp_data, rdat);
    chk({tag, ".rexc"}, {63'd0, is_d ? d_resp_exc : i_resp_exc}, {63'd0, rexc});
    tick();
    chk({tag, ".once"}, {62'd0, i_resp_valid, d_resp_valid}, 64'd0);
    chk({tag, ".hold"}, is_d ? d_resp_data : i_resp_data, rdat);
  endtask

  initial begin
    bit [9:0] seq;
    seq = 10'b1000010000;  // bit g set = I expected at grant g

    RESET = 1'b1;
    tick(); tick();
    RESET = 1'b0;
    #1;
    chk_zero("reset");

    xact("i_load", 1'b0, 1'b0, 8'h00, 64'h1000, 64'd0, 0, 64'h13, 1'b0);
    xact("d_store", 1'b1, 1'b1, 8'h0F, 64'h2008, 64'hDEADBEEF, 3, 64'd0, 1'b0);

    i_req_valid = 1'b1; i_req_addr = 64'h100;
    d_req_valid = 1'b1; d_req_addr = 64'h200; d_req_wren = 1'b0;
    d_req_mask = 8'hFF; d_req_data = 64'd0;
    mem_req_ready = 1'b1;
    for (int g = 0; g < 10; g++) begin
      #1;
      chk("arb.grant", {62'd0, i_req_ready, d_req_ready}, seq[g] ? 64'd2 : 64'd1);
      if (g > 0)
        chk("arb.route", {62'd0, i_resp_valid, d_resp_valid}, seq[g-1] ? 64'd2 : 64'd1);
      tick();
      #1;
      chk("arb.maddr", mem_addr, seq[g] ? 64'h100 : 64'h200);
      tick();
      mem_resp_valid = 1'b1;
      tick();
      mem_resp_valid = 1'b0;
    end
    #1;
    chk("arb.route_last", {62'd0, i_resp_valid, d_resp_valid}, 64'd2);
    i_req_valid = 1'b0; d_req_valid = 1'b0; mem_req_ready = 1'b0;
    tick();

    mem_resp_valid = 1'b1; mem_resp_data = 64'hBAD;
    tick();
    mem_resp_valid = 1'b0;
    #1;
    chk("spur.err", {63'd0, err_spurious}, 64'd1);
    chk("spur.rvld", {62'd0, i_resp_valid, d_resp_valid}, 64'd0);
    tick();
    chk("spur.sticky", {63'd0, err_spurious}, 64'd1);
    xact("spur.next", 1'b0, 1'b0, 8'h00, 64'h3000, 64'd0, 0, 64'h55, 1'b0);
    chk("spur.sticky2", {63'd0, err_spurious}, 64'd1);

    xact("d_exc", 1'b1, 1'b0, 8'hFF, 64'h4000, 64'd0, 1, 64'hAB, 1'b1);
    xact("i_noexc", 1'b0, 1'b0, 8'h00, 64'h4100, 64'd0, 0, 64'h77, 1'b0);

    i_req_valid = 1'b1; i_req_addr = 64'h5000;
    tick();
    i_req_valid = 1'b0; mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0; RESET = 1'b1;
    tick();
    RESET = 1'b0;
    #1;
    chk_zero("rst_resp");
    mem_resp_valid = 1'b1; mem_resp_data = 64'h99;
    tick();
    mem_resp_valid = 1'b0;
    #1;
    chk("late.rvld", {62'd0, i_resp_valid, d_resp_valid}, 64'd0);
    chk("late.err", {63'd0, err_spurious}, 64'd1);
    chk("late.mvld", {63'd0, mem_req_valid}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single memory port between the processor's instruction-fetch requester and its data-access requester. Accepts at most one transaction at a time, issues it to the memory, and routes the response back to the requester that owns it. Data accesses win by default, and a streak limit guarantees instruction fetch is never starved. Sits between the processor core and the RAM in the system top level.

## Interface
- STARVE_LIMIT, 4: maximum consecutive D grants while I is pending; range 1..15.
- CLK  in  1  the single clock; all state changes on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- i_req_valid  in  1  instruction-fetch request.
- i_req_addr  in  64  fetch address (PC).
- i_req_ready  out  1  I request accepted this cycle.
- i_resp_valid  out  1  one-cycle fetch response strobe.
- i_resp_data  out  64  fetched instruction word.
- i_resp_exc  out  1  fetch exception.
- d_req_valid  in  1  data request.
- d_req_wren  in  1  1 = store, 0 = load.
- d_req_mask  in  8  byte-enable mask.
- d_req_addr  in  64  data address.
- d_req_data  in  64  store data.
- d_req_ready  out  1  D request accepted this cycle.
- d_resp_valid  out  1  one-cycle data response strobe; also pulses for stores.
- d_resp_data  out  64  load data.
- d_resp_exc  out  1  data exception.
- mem_req_valid  out  1  request to memory.
- mem_req_ready  in  1  memory accepts request.
- mem_wren  out  1  to memory.
- mem_mask  out  8  to memory.
- mem_addr  out  64  to memory.
- mem_data  out  64  to memory.
- mem_resp_valid  in  1  memory response strobe.
- mem_resp_data  in  64  memory response data.
- mem_resp_exc  in  1  memory exception.
- err_spurious  out  1  sticky; a mem_resp_valid arrived outside RESP.

## Operation
- FSM states: IDLE, REQ, RESP.
- IDLE: arbitrate, then latch the winner's fields into the request register and set owner (I/D). Assert that requester's *_req_ready combinationally for exactly this cycle, then go to REQ. No valid requester: stay in IDLE.
- Arbitration: D wins, except when i_req_valid and streak == STARVE_LIMIT, in which case I wins. If only one requester is valid, it wins.
- streak (4-bit):
  - +1 on a D grant while i_req_valid=1.
  - Cleared on an I grant.
  - Cleared on a D grant while i_req_valid=0.
  - Saturates at STARVE_LIMIT.
- REQ: mem_req_valid=1 and mem_* driven from the register, held stable until mem_req_ready=1, then go to RESP.
- For I transactions: mem_wren=0, mem_mask=8'hFF, mem_data=0.
- RESP: wait for mem_resp_valid.
  - On the response, register data and exc into the owner's resp outputs.
  - Pulse the owner's *_resp_valid the next cycle; the other requester's resp_valid stays 0.
  - Go to IDLE.
- mem_resp_valid in IDLE or REQ is ignored and sets err_spurious, which clears only on RESET.
- At most one outstanding memory transaction.
- Requesters must hold valid and fields stable until ready; the block does not buffer unaccepted requests.

## Timing
- Reset values: state=IDLE, streak=0, all outputs 0, including err_spurious and the resp_data/exc registers.
- RESET asserted mid-transaction drops the transaction: no response is delivered to the requester, and a later mem_resp_valid sets err_spurious.
- Grant in cycle T (ready=1 at T). mem_req_valid goes high at T+1.
- mem_req_ready at T+1 gives RESP from T+2. Memory responds no earlier than the cycle after the handshake.
- mem_resp_valid at cycle R gives owner resp_valid=1 at R+1 only. The FSM is in IDLE at R+1 and can grant a new request in that same cycle.
- Minimum accept-to-response latency is 3 cycles, so peak throughput is one transaction per 3 cycles.
- resp_data/resp_exc hold their last value after the strobe.
- Simultaneous valid requests in IDLE: exactly one ready asserts; never both.

## Test plan
- Reset, then I load at addr 0x1000, memory ready immediately and responding 1 cycle later with 0x00000013 -> i_req_ready at T, mem_req_valid at T+1 with mem_addr=0x1000 and mem_wren=0, i_resp_valid at T+3 with data 0x13, d_resp_valid stays 0.
- D store: addr 0x2008, mask 8'h0F, data 0xDEADBEEF, memory stalls mem_req_ready for 3 cycles -> mem_* stable through the stall, d_resp_valid pulses once after mem_resp_valid, i_resp_valid stays 0.
- I and D both continuously valid, STARVE_LIMIT=4 -> grant sequence D,D,D,D,I,D,D,D,D,I, and no two readies in the same cycle.
- mem_resp_valid pulsed while in IDLE -> err_spurious=1 and stays 1, no resp strobes; next normal transaction completes correctly.
- RESET asserted while in RESP -> next cycle all outputs 0 and state IDLE; the late mem_resp_valid produces no resp strobe and sets err_spurious.
- D memory exception (mem_resp_exc=1) -> d_resp_exc=1 with d_resp_valid; next I response has i_resp_exc=0.
